shift_right_pipe: RTL and testbench

//  64-bit pipelined right barrel shifter; counterpart of the left-shift stage chain in the barrel-shifter core.
//  Six log-stages (1,2,4,8,16,32), each registered, with valid/ready flow control per stage.
//  Ops: logical right, arithmetic right (sign fill), optional rotate right. Sits between ALU operand mux and writeback.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_right_pipe_stage_ra.sv | 20 ++
 rtl/shift_right_pipe.sv | 71 +++++++
 tb/tb_shift_right_pipe.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared op encoding, widths and per-stage payload for the right-shift pipeline.
package shift_pkg;
  localparam int SHR_W      = 64;
  localparam int SHAMT_W    = 6;
  localparam int SHR_TAG_W  = 4;
  localparam int SHR_STAGES = 6;
  typedef enum logic [1:0] {
    SHR_LOG = 2'd0,
    SHR_ARI = 2'd1,
    SHR_ROT = 2'd2,
    SHR_RSV = 2'd3
  } shr_op_e;
  typedef struct packed {
    logic [SHR_W-1:0]     data;
    logic [SHAMT_W-1:0]   shamt;
    shr_op_e              op;
    logic                 fill;
    logic [SHR_TAG_W-1:0] tag;
  } shr_stage_t;
endpackage

// File: rtl/shift_right_pipe_stage_ra.sv
// stage_ra: one combinational right-shift step by SHAMT with zero/sign fill, or rotate when SHR_ROTATE_EN is defined.
module stage_ra
  import shift_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic [SHR_W-1:0] i_data,
  input  logic             i_en,
  input  shr_op_e          i_op,
  input  logic             i_fill,
  output logic [SHR_W-1:0] o_data
);
  logic [SHAMT-1:0] w_hi;
`ifdef SHR_ROTATE_EN
  assign w_hi = (i_op == SHR_ROT) ? i_data[SHAMT-1:0] : {SHAMT{(i_op == SHR_ARI) && i_fill}};
`else
  assign w_hi = {SHAMT{(i_op == SHR_ARI) && i_fill}};
`endif
  assign o_data = i_en ? {w_hi, i_data[SHR_W-1:SHAMT]} : i_data;
endmodule

// File: rtl/shift_right_pipe.sv
// shift_right_pipe: 6-stage registered 64-bit right barrel shifter with per-stage valid/ready.
// Rotate support is compiled in only when SHR_ROTATE_EN is defined.
module shift_right_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = SHR_W,
  parameter int TAG_W = SHR_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);
  logic [SHR_STAGES-1:0] r_v;
  shr_stage_t            r_p  [SHR_STAGES];
  logic [SHR_STAGES:0]   w_rdy;
  logic [SHR_STAGES-1:0] w_vin;
  shr_stage_t            w_in [SHR_STAGES];
  shr_stage_t            w_nx [SHR_STAGES];
  logic [SHR_W-1:0]      w_sh [SHR_STAGES];
  assign w_rdy[SHR_STAGES] = out_ready;
  for (genvar k = 0; k < SHR_STAGES; k++) begin : g_st
    // An empty stage always accepts, so bubbles collapse under a downstream stall.
    assign w_rdy[k] = !r_v[k] || w_rdy[k+1];
    if (k == 0) begin : g_first
      assign w_in[k]  = '{data: in_data, shamt: in_shamt, op: shr_op_e'(in_op),
                          fill: in_data[SHR_W-1], tag: in_tag};
      assign w_vin[k] = in_valid && !flush;
    end else begin : g_rest
      assign w_in[k]  = r_p[k-1];
      assign w_vin[k] = r_v[k-1];
    end
    stage_ra #(.SHAMT(1 << k)) u_stage (
      .i_data (w_in[k].data),
      .i_en   (w_in[k].shamt[k]),
      .i_op   (w_in[k].op),
      .i_fill (w_in[k].fill),
      .o_data (w_sh[k])
    );
    assign w_nx[k] = '{data: w_sh[k], shamt: w_in[k].shamt, op: w_in[k].op,
                       fill: w_in[k].fill, tag: w_in[k].tag};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < SHR_STAGES; i++) r_p[i] <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < SHR_STAGES; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_vin[i];
          if (w_vin[i]) r_p[i] <= w_nx[i];
        end
      end
    end
  end
  assign in_ready  = w_rdy[0] && !flush;
  assign out_valid = r_v[SHR_STAGES-1];
  assign out_data  = r_p[SHR_STAGES-1].data;
  assign out_tag   = r_p[SHR_STAGES-1].tag;
endmodule

// File: tb/tb_shift_right_pipe.sv
// tb_shift_right_pipe: directed checks of shift ops, latency, backpressure, flush and reset.
module tb_shift_right_pipe;
  logic        clk = 0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [5:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;
  int          errors = 0, checks = 0;

  shift_right_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sd(input int i);
    return 64'hF0F0_0000_0000_0000 | 64'(i);
  endfunction

  task automatic run_op(input string nm, input logic [1:0] op, input logic [63:0] d,
                        input logic [5:0] sh, input logic [3:0] tg, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    in_valid = 1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg; out_ready = 1;
    #1;
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'd6);
    check({nm, "_data"}, out_data, exp);
    check({nm, "_tag"}, 64'(out_tag), 64'(tg));
  endtask

  initial begin
    int tx, rx, seen;
    bit saw_full;
    logic [63:0] rot_exp;
    rst = 1; flush = 0; in_valid = 0; in_data = 0; in_shamt = 0; in_op = 0; in_tag = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("log_sh4", 2'd0, 64'h8000_0000_0000_0000, 6'd4, 4'h1, 64'h0800_0000_0000_0000);
    run_op("ari_neg63", 2'd1, 64'h8000_0000_0000_0000, 6'd63, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("ari_pos63", 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 4'h3, 64'h0);
    run_op("ari_sh4", 2'd1, 64'h8000_0000_0000_00F0, 6'd4, 4'h4, 64'hF800_0000_0000_000F);
`ifdef SHR_ROTATE_EN
    rot_exp = 64'h8000_0000_0000_0000;
`else
    rot_exp = 64'h0;
`endif
    run_op("rot_sh1", 2'd2, 64'h1, 6'd1, 4'h5, rot_exp);
    run_op("rsv_sh63", 2'd3, 64'h8000_0000_0000_0000, 6'd63, 4'h6, 64'h1);
    run_op("log_sh0", 2'd0, 64'hDEAD_BEEF_0123_4567, 6'd0, 4'h7, 64'hDEAD_BEEF_0123_4567);
    run_op("ari_sh0", 2'd1, 64'h8123_4567_89AB_CDEF, 6'd0, 4'h8, 64'h8123_4567_89AB_CDEF);
    run_op("rot_sh0", 2'd2, 64'h8000_0000_0000_0001, 6'd0, 4'h9, 64'h8000_0000_0000_0001);

    // Back-to-back stream with a downstream stall in cycles 8..12.
    tx = 0; rx = 0; saw_full = 0;
    for (int c = 0; c < 80 && rx < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 8 && c <= 12);
      in_valid = (tx < 16); in_op = 2'd0; in_data = sd(tx); in_shamt = tx[5:0]; in_tag = tx[3:0];
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("strm_data%0d", rx), out_data, sd(rx) >> rx);
        check($sformatf("strm_tag%0d", rx), 64'(out_tag), 64'(rx[3:0]));
        rx++;
      end
      if (tx < 16 && !in_ready) saw_full = 1;
      if (in_valid && in_ready) tx++;
    end
    in_valid = 0; out_ready = 1;
    check("strm_count", 64'(rx), 64'd16);
    check("strm_full_stall", 64'(saw_full), 64'd1);
    @(negedge clk);
    #1;
    check("strm_no_dup", 64'(out_valid), 64'd0);

    // Flush with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; in_op = 2'd0; in_data = 64'hFFFF_0000_FFFF_0000; in_shamt = 6'd8; in_tag = 4'(i);
    end
    @(negedge clk);
    flush = 1; in_tag = 4'hC;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 0; in_valid = 0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_none_emerge", 64'(seen), 64'd0);
    run_op("post_flush", 2'd1, 64'h8000_0000_0000_0000, 6'd1, 4'hA, 64'hC000_0000_0000_0000);

    // Reset while the pipeline is streaming.
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(negedge clk);
      in_valid = 1; in_op = 2'd0; in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_shamt = 6'd0; in_tag = 4'hF;
      #1;
    end
    check("rstm_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("rstm_out_valid", 64'(out_valid), 64'd0);
    check("rstm_out_data", out_data, 64'd0);
    check("rstm_out_tag", 64'(out_tag), 64'd0);
    check("rstm_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstm_none_emerge", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
